// File: rtl/sa_out_drain_pkg.sv
// Shared definitions for the systolic-array output drain.
// Default dimensions, the read FSM state type and an index-width helper.
package sa_out_drain_pkg;

   localparam int SA_D_W = 8;
   localparam int SA_DIM = 16;

   typedef enum logic {
      DRAIN_IDLE,
      DRAIN_STREAM
   } drain_state_e;

   // Width of an index that addresses n items; never narrower than one bit
   function automatic int idx_width(input int n);
      return (n <= 2) ? 1 : $clog2(n);
   endfunction

endpackage

// File: rtl/sa_drain_buf.sv
// Two-entry ping-pong matrix store for the output drain.
// Holds the write/read pointers and occupancy, accepts or drops incoming
// matrices, and offers one indexed read port on the entry under read.
// Build macro: SA_OUT_DRAIN_TRANSPOSE_EN selects column reads instead of rows.
module sa_drain_buf
   import sa_out_drain_pkg::*;
#(
   parameter int D_W   = SA_D_W,
   parameter int SA_R  = SA_DIM,
   parameter int SA_C  = SA_DIM,
   parameter int IDX_W = idx_width(SA_R)
) (
   input  logic                                 clk_i,
   input  logic                                 rst_ni,
   input  logic                                 wr_vld_i,
   input  logic [SA_R-1:0][SA_C-1:0][D_W-1:0]   wr_mat_i,
   input  logic                                 pop_i,
   input  logic [IDX_W-1:0]                     rd_idx_i,
   output logic [SA_C-1:0][D_W-1:0]             rd_data_o,
   output logic [1:0]                           cnt_o,
   output logic [1:0]                           cnt_next_o,
   output logic                                 drop_o
);

   logic [1:0][SA_R-1:0][SA_C-1:0][D_W-1:0] mem_q;
   logic [1:0] cnt_q, cnt_d;
   logic       wp_q, wp_d;
   logic       rp_q, rp_d;
   logic       accept;

   // A full store still accepts when an entry is being freed on the same edge
   always_comb begin
      accept = wr_vld_i && ((cnt_q != 2'd2) || pop_i);
      wp_d   = wp_q ^ accept;
      rp_d   = rp_q ^ pop_i;
      cnt_d  = cnt_q;
      case ({accept, pop_i})
         2'b10:   cnt_d = cnt_q + 2'd1;
         2'b01:   cnt_d = cnt_q - 2'd1;
         default: cnt_d = cnt_q;
      endcase
   end

   // Pointer and occupancy registers
   always_ff @(posedge clk_i or negedge rst_ni) begin
      if (!rst_ni) begin
         cnt_q <= 2'd0;
         wp_q  <= 1'b0;
         rp_q  <= 1'b0;
      end else begin
         cnt_q <= cnt_d;
         wp_q  <= wp_d;
         rp_q  <= rp_d;
      end
   end

   // Matrix storage is data only, so it carries no reset
   always_ff @(posedge clk_i) begin
      if (accept) begin
         mem_q[wp_q] <= wr_mat_i;
      end
   end

`ifdef SA_OUT_DRAIN_TRANSPOSE_EN
   // Column read: element k of the beat comes from row k of the entry
   always_comb begin
      rd_data_o = '0;
      for (int k = 0; k < SA_C; k++) begin
         rd_data_o[k] = mem_q[rp_q][k][rd_idx_i];
      end
   end
`else
   // Row read of the entry currently being drained
   always_comb begin
      rd_data_o = mem_q[rp_q][rd_idx_i];
   end
`endif

   assign cnt_o      = cnt_q;
   assign cnt_next_o = cnt_d;
   assign drop_o     = wr_vld_i && !accept;

endmodule

// File: rtl/sa_out_drain.sv
// Output drain for the systolic-array wrapper.
// Captures result matrices into a ping-pong store and streams them one beat
// per handshake downstream, with a sticky overflow flag for dropped strobes.
// Build macro: SA_OUT_DRAIN_TRANSPOSE_EN streams columns instead of rows
// (square arrays only).
module sa_out_drain
   import sa_out_drain_pkg::*;
#(
   parameter int D_W  = SA_D_W,
   parameter int SA_R = SA_DIM,
   parameter int SA_C = SA_DIM
) (
   input  logic                                 I_CLK,
   input  logic                                 I_RST_N,
   input  logic                                 I_MAT_VLD,
   input  logic [SA_R-1:0][SA_C-1:0][D_W-1:0]   I_MAT,
   output logic                                 O_MAT_RDY,
   output logic                                 O_ROW_VLD,
   input  logic                                 I_ROW_RDY,
   output logic [SA_C-1:0][D_W-1:0]             O_ROW,
   output logic [idx_width(SA_R)-1:0]           O_ROW_IDX,
   output logic                                 O_ROW_LAST,
   output logic                                 O_OVERFLOW
);

   localparam int IDX_W = idx_width(SA_R);

`ifdef SA_OUT_DRAIN_TRANSPOSE_EN
   localparam int NBEATS = SA_C;
   if (SA_R != SA_C) begin : g_transpose_needs_square
      $error("sa_out_drain: column streaming requires SA_R == SA_C");
   end
`else
   localparam int NBEATS = SA_R;
`endif

   localparam logic [IDX_W-1:0] LAST_IDX = IDX_W'(NBEATS - 1);

   drain_state_e           state_q, state_d;
   logic [IDX_W-1:0]       row_q, row_d;
   logic                   ovf_q;
   logic                   streaming;
   logic                   xfer;
   logic                   at_last;
   logic                   pop;
   logic [1:0]             cnt;
   logic [1:0]             cnt_next;
   logic                   drop;
   logic [SA_C-1:0][D_W-1:0] rd_data;

   sa_drain_buf #(
      .D_W   (D_W),
      .SA_R  (SA_R),
      .SA_C  (SA_C),
      .IDX_W (IDX_W)
   ) u_buf (
      .clk_i      (I_CLK),
      .rst_ni     (I_RST_N),
      .wr_vld_i   (I_MAT_VLD),
      .wr_mat_i   (I_MAT),
      .pop_i      (pop),
      .rd_idx_i   (row_q),
      .rd_data_o  (rd_data),
      .cnt_o      (cnt),
      .cnt_next_o (cnt_next),
      .drop_o     (drop)
   );

   assign streaming = (state_q == DRAIN_STREAM);
   assign xfer      = streaming && I_ROW_RDY;
   assign at_last   = streaming && (row_q == LAST_IDX);
   assign pop       = xfer && at_last;

   // Next state looks at post-edge occupancy so a capture streams one cycle
   // later and back-to-back matrices follow without a bubble
   always_comb begin
      state_d = state_q;
      row_d   = row_q;
      case (state_q)
         DRAIN_IDLE: begin
            if (cnt_next != 2'd0) begin
               state_d = DRAIN_STREAM;
            end
         end
         DRAIN_STREAM: begin
            if (xfer) begin
               if (at_last) begin
                  row_d = '0;
                  if (cnt_next == 2'd0) begin
                     state_d = DRAIN_IDLE;
                  end
               end else begin
                  row_d = row_q + 1'b1;
               end
            end
         end
         default: begin
            state_d = DRAIN_IDLE;
            row_d   = '0;
         end
      endcase
   end

   // Read FSM and beat counter registers
   always_ff @(posedge I_CLK or negedge I_RST_N) begin
      if (!I_RST_N) begin
         state_q <= DRAIN_IDLE;
         row_q   <= '0;
      end else begin
         state_q <= state_d;
         row_q   <= row_d;
      end
   end

   // Overflow stays set until reset once any strobe is dropped
   always_ff @(posedge I_CLK or negedge I_RST_N) begin
      if (!I_RST_N) begin
         ovf_q <= 1'b0;
      end else if (drop) begin
         ovf_q <= 1'b1;
      end
   end

   assign O_ROW_VLD  = streaming;
   assign O_ROW      = streaming ? rd_data : '0;
   assign O_ROW_IDX  = streaming ? row_q : '0;
   assign O_ROW_LAST = at_last;
   assign O_MAT_RDY  = (cnt != 2'd2);
   assign O_OVERFLOW = ovf_q;

endmodule

// File: tb/tb_sa_out_drain.sv
// Self-checking bench for sa_out_drain: directed scenarios plus random
// traffic, compared every cycle against a queue-based reference model.
`timescale 1ns/1ps
module tb_sa_out_drain;

   localparam int D_W  = 8;
   localparam int SA_R = 16;
   localparam int SA_C = 16;
`ifdef SA_OUT_DRAIN_TRANSPOSE_EN
   localparam int NB = SA_C;
`else
   localparam int NB = SA_R;
`endif

   typedef logic [SA_R-1:0][SA_C-1:0][D_W-1:0] mat_t;
   typedef logic [SA_C-1:0][D_W-1:0]           row_t;

   logic       I_CLK = 1'b0;
   logic       I_RST_N;
   logic       I_MAT_VLD;
   mat_t       I_MAT;
   logic       O_MAT_RDY;
   logic       O_ROW_VLD;
   logic       I_ROW_RDY;
   row_t       O_ROW;
   logic [3:0] O_ROW_IDX;
   logic       O_ROW_LAST;
   logic       O_OVERFLOW;

   sa_out_drain #(.D_W(D_W), .SA_R(SA_R), .SA_C(SA_C)) dut (
      .I_CLK      (I_CLK),
      .I_RST_N    (I_RST_N),
      .I_MAT_VLD  (I_MAT_VLD),
      .I_MAT      (I_MAT),
      .O_MAT_RDY  (O_MAT_RDY),
      .O_ROW_VLD  (O_ROW_VLD),
      .I_ROW_RDY  (I_ROW_RDY),
      .O_ROW      (O_ROW),
      .O_ROW_IDX  (O_ROW_IDX),
      .O_ROW_LAST (O_ROW_LAST),
      .O_OVERFLOW (O_OVERFLOW)
   );

   always #5 I_CLK = ~I_CLK;

   int total = 0;
   int bad   = 0;

   // Reference model: pending matrices in arrival order, beat within head
   mat_t mq[$];
   int   beat;
   bit   ovf;

   task automatic checkOutput(input string name, input logic [SA_C*D_W-1:0] act,
                              input logic [SA_C*D_W-1:0] exp);
      total++;
      if (act !== exp) begin
         bad++;
         $display("[TB] FAIL %s: got %h expected %h at %0t", name, act, exp, $time);
      end
   endtask

   function automatic row_t expRow(input mat_t m, input int b);
      row_t r;
      r = '0;
`ifdef SA_OUT_DRAIN_TRANSPOSE_EN
      for (int k = 0; k < SA_C; k++) r[k] = m[k][b];
`else
      r = m[b];
`endif
      return r;
   endfunction

   function automatic mat_t randMat();
      mat_t m;
      for (int i = 0; i < SA_R; i++)
         for (int j = 0; j < SA_C; j++)
            m[i][j] = 8'($urandom);
      return m;
   endfunction

   function automatic mat_t fillMat(input logic [7:0] v);
      mat_t m;
      for (int i = 0; i < SA_R; i++)
         for (int j = 0; j < SA_C; j++)
            m[i][j] = v;
      return m;
   endfunction

   // Model update on each edge, then compare the DUT shortly after it
   always @(posedge I_CLK or negedge I_RST_N) begin
      if (!I_RST_N) begin
         mq.delete();
         beat = 0;
         ovf  = 1'b0;
      end else begin : upd
         int pre;
         bit popped;
         pre    = mq.size();
         popped = 1'b0;
         if (pre > 0 && I_ROW_RDY) begin
            if (beat == NB - 1) begin
               void'(mq.pop_front());
               beat   = 0;
               popped = 1'b1;
            end else begin
               beat++;
            end
         end
         if (I_MAT_VLD) begin
            if (pre < 2 || popped) mq.push_back(I_MAT);
            else ovf = 1'b1;
         end
         #1;
         checkOutput("vld", O_ROW_VLD, mq.size() > 0);
         checkOutput("mat_rdy", O_MAT_RDY, mq.size() < 2);
         checkOutput("overflow", O_OVERFLOW, ovf);
         if (mq.size() > 0) begin
            checkOutput("row", O_ROW, expRow(mq[0], beat));
            checkOutput("idx", O_ROW_IDX, beat);
            checkOutput("last", O_ROW_LAST, beat == NB - 1);
         end
      end
   end

   // Drive inputs for the next edge, then advance to the following negedge
   task automatic applyStimulus(input bit vld, input mat_t m, input bit rdy);
      I_MAT_VLD = vld;
      I_MAT     = m;
      I_ROW_RDY = rdy;
      @(negedge I_CLK);
   endtask

   task automatic idle(input int n, input bit rdy);
      for (int k = 0; k < n; k++) applyStimulus(1'b0, I_MAT, rdy);
   endtask

   task automatic waitIdx(input int idx, output bit found);
      found = 1'b0;
      for (int k = 0; k < 60 && !found; k++) begin
         if (O_ROW_VLD && O_ROW_IDX == 4'(idx)) found = 1'b1;
         else applyStimulus(1'b0, I_MAT, 1'b1);
      end
      if (!found) checkOutput("wait_timeout", 0, 1);
   endtask

   task automatic pulseReset();
      I_RST_N = 1'b0;
      @(negedge I_CLK);
      I_RST_N = 1'b1;
   endtask

   initial begin
      mat_t m, a, b, c;
      row_t r;
      bit   found;

      I_RST_N   = 1'b0;
      I_MAT_VLD = 1'b0;
      I_ROW_RDY = 1'b0;
      I_MAT     = '0;
      repeat (3) @(negedge I_CLK);
      checkOutput("rst_vld", O_ROW_VLD, 0);
      checkOutput("rst_mat_rdy", O_MAT_RDY, 1);
      checkOutput("rst_ovf", O_OVERFLOW, 0);
      checkOutput("rst_row", O_ROW, 0);
      I_RST_N = 1'b1;
      @(negedge I_CLK);

      // Basic drain with a known pattern
      for (int i = 0; i < SA_R; i++)
         for (int j = 0; j < SA_C; j++)
            m[i][j] = 8'((16 * i + j) % 256);
      applyStimulus(1'b1, m, 1'b1);
      checkOutput("basic_first_vld", O_ROW_VLD, 1);
      checkOutput("basic_first_idx", O_ROW_IDX, 0);
      idle(3, 1'b1);
      for (int j = 0; j < SA_C; j++) r[j] = 8'(8'h30 + j);
`ifndef SA_OUT_DRAIN_TRANSPOSE_EN
      checkOutput("basic_beat3_row", O_ROW, r);
`endif
      checkOutput("basic_beat3_idx", O_ROW_IDX, 3);
      checkOutput("basic_beat3_last", O_ROW_LAST, 0);
      idle(12, 1'b1);
      checkOutput("basic_beat15_last", O_ROW_LAST, 1);
      idle(4, 1'b1);

      // Backpressure with a 1,0,0,1 ready pattern
      applyStimulus(1'b1, randMat(), 1'b1);
      for (int k = 0; k < 70; k++)
         applyStimulus(1'b0, I_MAT, (k % 4 == 0) || (k % 4 == 3));
      idle(4, 1'b1);

      // Ping-pong: two matrices back to back
      a = fillMat(8'h11);
      b = fillMat(8'h22);
      applyStimulus(1'b1, a, 1'b1);
      applyStimulus(1'b1, b, 1'b1);
      checkOutput("pp_mat_rdy_full", O_MAT_RDY, 0);
      idle(40, 1'b1);

      // Overflow: third strobe while stalled and full
      c = fillMat(8'h33);
      applyStimulus(1'b1, a, 1'b0);
      applyStimulus(1'b1, b, 1'b0);
      applyStimulus(1'b1, c, 1'b0);
      checkOutput("ovf_set", O_OVERFLOW, 1);
      idle(45, 1'b1);
      checkOutput("ovf_sticky", O_OVERFLOW, 1);

      // Strobe on the last beat of a full store is accepted
      pulseReset();
      applyStimulus(1'b1, a, 1'b1);
      applyStimulus(1'b1, b, 1'b1);
      waitIdx(15, found);
      applyStimulus(1'b1, c, 1'b1);
      checkOutput("sim_ovf_clear", O_OVERFLOW, 0);
      checkOutput("sim_mat_rdy", O_MAT_RDY, 0);
      idle(40, 1'b1);

      // Mid-stream asynchronous reset
      applyStimulus(1'b1, randMat(), 1'b1);
      waitIdx(7, found);
      #2 I_RST_N = 1'b0;
      #1;
      checkOutput("mrst_vld", O_ROW_VLD, 0);
      checkOutput("mrst_row", O_ROW, 0);
      checkOutput("mrst_idx", O_ROW_IDX, 0);
      checkOutput("mrst_last", O_ROW_LAST, 0);
      checkOutput("mrst_mat_rdy", O_MAT_RDY, 1);
      @(negedge I_CLK);
      I_RST_N = 1'b1;
      idle(3, 1'b1);
      checkOutput("mrst_idle_vld", O_ROW_VLD, 0);
      checkOutput("mrst_idle_rdy", O_MAT_RDY, 1);

      // Random traffic
      for (int k = 0; k < 800; k++)
         applyStimulus($urandom_range(0, 9) == 0, randMat(), $urandom_range(0, 3) != 0);
      idle(40, 1'b1);

      $display("test done: total=%0d bad=%0d", total, bad);
      $finish;
   end

endmodule

// File: doc/sa_out_drain.md
# sa_out_drain

Output-side drain for the systolic-array wrapper. It captures each completed D_W-bit SA_R×SA_C result matrix the array presents on its out-valid pulse into a two-entry ping-pong buffer. It then streams the matrix one row per beat to the downstream consumer, such as the softmax/scaling stage, using a valid/ready handshake. It is the reader for the array's matrix writer and exposes backpressure to the array controller.

## Interface
- D_W, 8, element width in bits
- SA_R, 16, matrix rows
- SA_C, 16, matrix columns
- I_CLK  in  1  clock; all state updates on rising edge
- I_RST_N  in  1  asynchronous active-low reset
- I_MAT_VLD  in  1  single-cycle capture strobe (from array O_OUT_VLD)
- I_MAT  in  D_W × [SA_R][SA_C]  result matrix, sampled when I_MAT_VLD=1
- O_MAT_RDY  out  1  at least one buffer entry free
- O_ROW_VLD  out  1  O_ROW holds a valid beat
- I_ROW_RDY  in  1  downstream accepts beat
- O_ROW  out  D_W × [SA_C]  current row (row-major, element 0 = column 0)
- O_ROW_IDX  out  $clog2(SA_R)  index of current row
- O_ROW_LAST  out  1  current beat is the final row of the matrix
- O_OVERFLOW  out  1  sticky; a strobe arrived while no entry was free

## Operation
- Storage: two entries buf[0..1], write pointer wp, read pointer rp, occupancy cnt ∈ {0,1,2}.
- Capture: I_MAT_VLD && cnt<2 → buf[wp] ← I_MAT, wp toggles, cnt+1.
- Drop: I_MAT_VLD && cnt==2 → matrix discarded, O_OVERFLOW ← 1. Only reset clears O_OVERFLOW. Stored data is untouched.
- Read FSM, two states:
  - IDLE: O_ROW_VLD=0. Go to STREAM when cnt>0 at a clock edge.
  - STREAM: O_ROW_VLD=1, O_ROW=buf[rp][row], O_ROW_IDX=row, O_ROW_LAST=(row==SA_R-1).
- Beat transfer occurs when O_ROW_VLD && I_ROW_RDY. On a non-last beat, row+1.
- On a last beat: row←0, rp toggles, cnt−1. The FSM stays in STREAM if the post-update cnt>0, otherwise it returns to IDLE.
- Simultaneous capture and last-beat transfer: both take effect and cnt is unchanged.
- O_MAT_RDY = (cnt<2), decoded from registers only. It never depends combinationally on I_ROW_RDY.
- While O_ROW_VLD=1 and I_ROW_RDY=0, O_ROW, O_ROW_IDX and O_ROW_LAST hold stable. O_ROW_VLD must not drop without a transfer.

## Timing
- Reset (asynchronous): cnt=0, wp=rp=0, row=0, FSM=IDLE. Outputs: O_ROW_VLD=0, O_ROW=0, O_ROW_IDX=0, O_ROW_LAST=0, O_OVERFLOW=0, O_MAT_RDY=1. Buffer contents are not reset.
- Capture-to-first-beat latency is 1 cycle. A strobe at edge t into an empty block gives O_ROW_VLD=1 after edge t.
- With I_ROW_RDY held high, a matrix drains in exactly SA_R consecutive cycles. Back-to-back matrices stream with zero bubble beats.
- O_MAT_RDY reflects occupancy after each edge. A strobe in the same cycle as the last-beat transfer is accepted even when cnt==2 before the edge, because the freed entry is reused. O_OVERFLOW is not set in that case.
- Reset asserted mid-stream aborts immediately. All buffered matrices are lost and the block is empty on release.

## Configuration
- SA_OUT_DRAIN_TRANSPOSE_EN
  - Defined: beats are columns. O_ROW[k]=buf[rp][k][col], O_ROW_IDX=column index, a matrix takes SA_C beats. Requires SA_R==SA_C; an elaboration-time check fails otherwise.
  - Undefined: row-major as described above.

## Structure
- The shared package holds:
  - default constants SA_D_W=8 and SA_DIM=16
  - the drain FSM enum (DRAIN_IDLE, DRAIN_STREAM)
  - a helper function computing the index width
- One sub-module, sa_drain_buf, contains:
  - the ping-pong storage, wp/rp/cnt, and the write/drop logic
  - an indexed read port (entry, row or column)
- The top level contains the read FSM, the row counter, the handshake and O_OVERFLOW.

## Test plan
- Basic drain: matrix M[i][j]=(16i+j) mod 256, strobe once, I_ROW_RDY=1 → 16 beats on consecutive cycles, beat 3 O_ROW[j]=0x30+j, O_ROW_LAST=1 only on IDX=15, O_MAT_RDY=1 throughout.
- Backpressure: I_ROW_RDY toggled 1,0,0,1,… → each beat is held stable while stalled, all 16 rows are delivered in order, and there are no duplicates.
- Ping-pong: strobes A (all 0x11) and B (all 0x22) on consecutive cycles → O_MAT_RDY=0 after B, output is 16 beats of 0x11 then 16 beats of 0x22 with no gap.
- Overflow: with I_ROW_RDY=0, strobe A, B, C → O_OVERFLOW=1 after C. Releasing ready yields A then B only.
- Simultaneous event: with cnt==2, strobe C in the same cycle as A's last beat → C is accepted, O_OVERFLOW stays 0, and output order is A, B, C.
- Mid-stream reset: assert I_RST_N=0 at beat 7 → all outputs reach their reset values asynchronously. The block is idle with O_MAT_RDY=1 after release.
